exec_unit: RTL and testbench

//  Downstream stage of program fetch. Registers each 16-bit word from prog_memory with its address
//  and executes it against a small accumulator datapath.

---
 rtl/exec_unit_if.sv | 43 ++++
 rtl/exec_unit.sv | 143 ++++++++++++++
 tb/tb_exec_unit.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/exec_unit_if.sv
// Program-fetch / execute boundary bundle: word and address in from fetch,
// PC load port and I/O outputs back out. exec_unit connects through the slave modport.
interface exec_unit_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned ACC_W  = 10
);

  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic              pc_load_en;
  logic [ADDR_W-1:0] pc_load_data;
  logic [ACC_W-1:0]  port_out;
  logic              port_strobe;
  logic              clk_light;
  logic              halted;
  logic              illegal_op;

  modport master (
    output prog_addr,
    output prog_data,
    input  pc_load_en,
    input  pc_load_data,
    input  port_out,
    input  port_strobe,
    input  clk_light,
    input  halted,
    input  illegal_op
  );

  modport slave (
    input  prog_addr,
    input  prog_data,
    output pc_load_en,
    output pc_load_data,
    output port_out,
    output port_strobe,
    output clk_light,
    output halted,
    output illegal_op
  );

endinterface

// File: rtl/exec_unit.sv
// Execute stage: registers each fetched word with its address, runs it against a
// small accumulator datapath one edge later, and steers the PC for jumps and halt.
module exec_unit #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned ACC_W  = 10
) (
  input  logic       sys_clk,
  input  logic       reset,
  exec_unit_if.slave bus
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_ADDI = 4'h2,
    OP_SUBI = 4'h3,
    OP_JMP  = 4'h4,
    OP_JZ   = 4'h5,
    OP_OUT  = 4'h6,
    OP_TGL  = 4'h7,
    OP_HALT = 4'hF
  } opcode_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0] ir_addr_q, ir_addr_d;
  logic              ir_valid_q, ir_valid_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              zero_q, zero_d;
  logic [ACC_W-1:0]  port_out_q, port_out_d;
  logic              port_strobe_q, port_strobe_d;
  logic              clk_light_q, clk_light_d;
  logic              illegal_op_q, illegal_op_d;

  opcode_e           op;
  logic [11:0]       imm;
  logic [ACC_W-1:0]  imm_acc;
  logic [ACC_W-1:0]  alu_res;
  logic              alu_wr;
  logic              exec;
  logic              taken;
  logic              pc_load_en;
  logic [ADDR_W-1:0] pc_load_data;

  assign op      = opcode_e'(ir_q[DATA_W-1:DATA_W-4]);
  assign imm     = ir_q[11:0];
  assign imm_acc = imm[ACC_W-1:0];

  always_comb begin
    state_d       = state_q;
    ir_d          = ir_q;
    ir_addr_d     = ir_addr_q;
    ir_valid_d    = 1'b0;
    acc_d         = acc_q;
    zero_d        = zero_q;
    port_out_d    = port_out_q;
    port_strobe_d = 1'b0;
    clk_light_d   = clk_light_q;
    illegal_op_d  = illegal_op_q;
    alu_res       = acc_q;
    alu_wr        = 1'b0;
    taken         = 1'b0;
    pc_load_en    = 1'b0;
    pc_load_data  = '0;
    exec          = ir_valid_q && (state_q == ST_RUN);

    if (exec) begin
      case (op)
        OP_NOP:  ;
        OP_LDI:  begin alu_res = imm_acc;         alu_wr = 1'b1; end
        OP_ADDI: begin alu_res = acc_q + imm_acc; alu_wr = 1'b1; end
        OP_SUBI: begin alu_res = acc_q - imm_acc; alu_wr = 1'b1; end
        OP_JMP:  taken = 1'b1;
        OP_JZ:   taken = zero_q;
        OP_OUT:  begin port_out_d = acc_q; port_strobe_d = 1'b1; end
        OP_TGL:  clk_light_d = ~clk_light_q;
        OP_HALT: state_d = ST_HALT;
        default: illegal_op_d = 1'b1;
      endcase
    end

    if (alu_wr) begin
      acc_d  = alu_res;
      zero_d = (alu_res == '0);
    end

    // The HALT edge skips capture so ir_addr keeps the halt address for the PC hold.
    if ((state_q == ST_RUN) && (state_d == ST_RUN)) begin
      ir_d       = bus.prog_data;
      ir_addr_d  = bus.prog_addr;
      ir_valid_d = !taken;
    end

    if (state_q == ST_HALT) begin
      pc_load_en   = 1'b1;
      pc_load_data = ir_addr_q;
    end else if (taken) begin
      pc_load_en   = 1'b1;
      pc_load_data = ADDR_W'(imm);
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_RUN;
      ir_q          <= '0;
      ir_addr_q     <= '0;
      ir_valid_q    <= 1'b0;
      acc_q         <= '0;
      zero_q        <= 1'b0;
      port_out_q    <= '0;
      port_strobe_q <= 1'b0;
      clk_light_q   <= 1'b0;
      illegal_op_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      ir_q          <= ir_d;
      ir_addr_q     <= ir_addr_d;
      ir_valid_q    <= ir_valid_d;
      acc_q         <= acc_d;
      zero_q        <= zero_d;
      port_out_q    <= port_out_d;
      port_strobe_q <= port_strobe_d;
      clk_light_q   <= clk_light_d;
      illegal_op_q  <= illegal_op_d;
    end
  end

  assign bus.pc_load_en   = pc_load_en;
  assign bus.pc_load_data = pc_load_data;
  assign bus.port_out     = port_out_q;
  assign bus.port_strobe  = port_strobe_q;
  assign bus.clk_light    = clk_light_q;
  assign bus.halted       = (state_q == ST_HALT);
  assign bus.illegal_op   = illegal_op_q;

endmodule

// File: tb/tb_exec_unit.sv
// Bench for exec_unit: a behavioural PC + program memory around the DUT, directed
// scenarios, then random programs checked against an instruction-level model.
module tb_exec_unit;

  localparam int ACC_MOD = 1024;

  logic        sys_clk = 1'b0;
  logic        reset   = 1'b1;
  logic [15:0] pc      = 16'h0;
  logic [15:0] mem [0:4095];

  int total = 0;
  int bad   = 0;

  // instruction-level model: one pending instruction plus architectural state
  logic        m_valid;
  logic [15:0] m_word;
  logic [15:0] m_addr;
  int          m_acc;
  bit          m_zero, m_halt, m_strobe, m_light, m_illegal;
  int          m_port;

  exec_unit_if #(.DATA_W(16), .ADDR_W(16), .ACC_W(10)) bus ();

  assign bus.prog_addr = pc;
  assign bus.prog_data = mem[pc[11:0]];

  exec_unit #(.DATA_W(16), .ADDR_W(16), .ACC_W(10)) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_valid = 1'b0; m_word = 16'h0; m_addr = 16'h0; m_acc = 0; m_zero = 1'b0;
    m_halt = 1'b0; m_strobe = 1'b0; m_light = 1'b0; m_illegal = 1'b0; m_port = 0;
  endtask

  function automatic bit exp_le();
    int op;
    op = int'(m_word[15:12]);
    return m_halt || (m_valid && (op == 4 || (op == 5 && m_zero)));
  endfunction

  function automatic logic [15:0] exp_data();
    if (m_halt) return m_addr;
    if (exp_le()) return {4'h0, m_word[11:0]};
    return 16'h0;
  endfunction

  task automatic model_edge(input logic [15:0] fetched, input logic [15:0] faddr);
    int op, imm;
    bit taken;
    m_strobe = 1'b0;
    if (m_halt) return;
    op    = int'(m_word[15:12]);
    imm   = int'(m_word[11:0]);
    taken = 1'b0;
    if (m_valid) begin
      case (op)
        0: ;
        1: begin m_acc = imm % ACC_MOD; m_zero = (m_acc == 0); end
        2: begin m_acc = (m_acc + imm) % ACC_MOD; m_zero = (m_acc == 0); end
        3: begin m_acc = (m_acc - (imm % ACC_MOD) + ACC_MOD) % ACC_MOD; m_zero = (m_acc == 0); end
        4: taken = 1'b1;
        5: taken = m_zero;
        6: begin m_port = m_acc; m_strobe = 1'b1; end
        7: m_light = !m_light;
        15: begin m_halt = 1'b1; m_valid = 1'b0; return; end
        default: m_illegal = 1'b1;
      endcase
    end
    m_word  = fetched;
    m_addr  = faddr;
    m_valid = !taken;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".load_en"},   32'(bus.pc_load_en),   32'(exp_le()));
    chk({tag, ".load_data"}, 32'(bus.pc_load_data), 32'(exp_data()));
    chk({tag, ".port_out"},  32'(bus.port_out),     32'(m_port));
    chk({tag, ".strobe"},    32'(bus.port_strobe),  32'(m_strobe));
    chk({tag, ".light"},     32'(bus.clk_light),    32'(m_light));
    chk({tag, ".halted"},    32'(bus.halted),       32'(m_halt));
    chk({tag, ".illegal"},   32'(bus.illegal_op),   32'(m_illegal));
  endtask

  // one clock edge: PC follows the DUT's load port like the real prog_counter
  task automatic tick(input string tag);
    logic [15:0] a, d, ld;
    logic        le;
    a  = pc;
    d  = mem[pc[11:0]];
    le = bus.pc_load_en;
    ld = bus.pc_load_data;
    @(posedge sys_clk);
    #1;
    model_edge(d, a);
    pc = le ? ld : pc + 16'h1;
    check_all(tag);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, ".load_en"},   32'(bus.pc_load_en),   32'h0);
    chk({tag, ".load_data"}, 32'(bus.pc_load_data), 32'h0);
    chk({tag, ".port_out"},  32'(bus.port_out),     32'h0);
    chk({tag, ".strobe"},    32'(bus.port_strobe),  32'h0);
    chk({tag, ".light"},     32'(bus.clk_light),    32'h0);
    chk({tag, ".halted"},    32'(bus.halted),       32'h0);
    chk({tag, ".illegal"},   32'(bus.illegal_op),   32'h0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    pc    = 16'h0;
    model_clear();
    @(posedge sys_clk);
    #1;
    check_zero_outputs(tag);
    @(posedge sys_clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
  endtask

  initial begin
    int op, imm;
    model_clear();
    clear_mem();

    // T1: first fetch after reset, OUT strobe on the third edge
    mem[0] = 16'h1005;
    mem[1] = 16'h6000;
    do_reset("t1_rst");
    tick("t1_e1");
    chk("t1_e1_strobe", 32'(bus.port_strobe), 32'h0);
    tick("t1_e2");
    chk("t1_e2_strobe", 32'(bus.port_strobe), 32'h0);
    tick("t1_e3");
    chk("t1_e3_strobe", 32'(bus.port_strobe), 32'h1);
    chk("t1_e3_port",   32'(bus.port_out),    32'h5);

    // T2: accumulator wrap sets zero, JZ taken with a single bubble
    clear_mem();
    mem[16'h000] = 16'h13FF;
    mem[16'h001] = 16'h2001;
    mem[16'h002] = 16'h5010;
    mem[16'h003] = 16'h6000;
    mem[16'h010] = 16'h7000;
    mem[16'h011] = 16'hF000;
    do_reset("t2_rst");
    tick("t2_e1");
    tick("t2_e2");
    tick("t2_e3");
    chk("t2_jz_le",   32'(bus.pc_load_en),   32'h1);
    chk("t2_jz_data", 32'(bus.pc_load_data), 32'h010);
    tick("t2_e4");
    chk("t2_bubble_le", 32'(bus.pc_load_en), 32'h0);
    chk("t2_target_pc", 32'(pc),             32'h010);
    tick("t2_e5");
    chk("t2_e5_light", 32'(bus.clk_light), 32'h0);
    tick("t2_e6");
    chk("t2_e6_light", 32'(bus.clk_light), 32'h1);
    for (int i = 0; i < 6; i++) begin
      tick("t2_run");
      chk("t2_no_out", 32'(bus.port_strobe), 32'h0);
    end

    // T3: not-taken JZ, OUT right behind it
    clear_mem();
    mem[0] = 16'h1001;
    mem[1] = 16'h5020;
    mem[2] = 16'h6000;
    mem[3] = 16'hF000;
    do_reset("t3_rst");
    tick("t3_e1");
    tick("t3_e2");
    chk("t3_jz_le", 32'(bus.pc_load_en), 32'h0);
    tick("t3_e3");
    chk("t3_e3_le", 32'(bus.pc_load_en), 32'h0);
    tick("t3_e4");
    chk("t3_strobe", 32'(bus.port_strobe), 32'h1);
    chk("t3_port",   32'(bus.port_out),    32'h1);

    // T4: toggle then halt at 0x002, PC held there indefinitely
    clear_mem();
    mem[0] = 16'h7000;
    mem[1] = 16'h0000;
    mem[2] = 16'hF000;
    mem[3] = 16'h6000;
    do_reset("t4_rst");
    for (int i = 0; i < 4; i++) tick("t4_pre");
    chk("t4_halted", 32'(bus.halted),       32'h1);
    chk("t4_light",  32'(bus.clk_light),    32'h1);
    chk("t4_le",     32'(bus.pc_load_en),   32'h1);
    chk("t4_data",   32'(bus.pc_load_data), 32'h002);
    for (int i = 0; i < 105; i++) begin
      tick("t4_hold");
      chk("t4_hold_le",   32'(bus.pc_load_en),   32'h1);
      chk("t4_hold_data", 32'(bus.pc_load_data), 32'h002);
      chk("t4_hold_pc",   32'(pc),               32'h002);
      chk("t4_hold_out",  32'(bus.port_strobe),  32'h0);
    end

    // T5: illegal opcode is sticky and leaves acc alone; reset during a taken JMP
    clear_mem();
    mem[0] = 16'h1011;
    mem[1] = 16'h9000;
    mem[2] = 16'h6000;
    mem[3] = 16'h4000;
    do_reset("t5_rst");
    tick("t5_e1");
    tick("t5_e2");
    tick("t5_e3");
    chk("t5_illegal", 32'(bus.illegal_op), 32'h1);
    tick("t5_e4");
    chk("t5_port_acc", 32'(bus.port_out),   32'h011);
    chk("t5_jmp_le",   32'(bus.pc_load_en), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check_zero_outputs("t5_async");
    do_reset("t5_rst2");
    tick("t5_restart");
    chk("t5_restart_pc", 32'(pc), 32'h1);

    // T6: self-jump alternates jump and bubble
    clear_mem();
    mem[4] = 16'h4004;
    do_reset("t6_rst");
    for (int i = 0; i < 5; i++) tick("t6_pre");
    for (int k = 0; k < 8; k++) begin
      chk("t6_le",   32'(bus.pc_load_en), (k % 2 == 0) ? 32'h1 : 32'h0);
      chk("t6_addr", 32'(pc),             (k % 2 == 0) ? 32'h5 : 32'h4);
      if (k % 2 == 0) chk("t6_data", 32'(bus.pc_load_data), 32'h004);
      tick("t6_loop");
    end

    // random programs in 0..63 against the model
    for (int p = 0; p < 4; p++) begin
      clear_mem();
      for (int i = 0; i < 64; i++) begin
        op = int'($urandom_range(0, 15));
        if (op == 15 && $urandom_range(0, 7) != 0) op = 0;
        if (op == 4 || op == 5) imm = int'($urandom_range(0, 63));
        else if ($urandom_range(0, 3) == 0) imm = 0;
        else imm = int'($urandom_range(0, 4095));
        mem[i] = {4'(op), 12'(imm)};
      end
      do_reset("rnd_rst");
      for (int c = 0; c < 300; c++) tick("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
